decode_ctrl_stage: RTL and testbench
====================================

// Module: decode_ctrl_stage
// PURPOSE
//  Registered decode/control stage between fetch and execute, replacing the purely combinational control decoder.
//  Decodes the RV32I instruction (optionally RV32M), flags illegal encodings, and inserts one bubble on load-use hazards.
//  Holds one decoded instruction. Uses valid/ready handshakes on both sides and supports a flush input for taken branches and jumps.
// PARAMETERS
//  ENABLE_M      0   1: decode RV32M (opcode 0110011, funct7 0000001); 0: those encodings are illegal
//  ENABLE_HAZARD 1   1: load-use bubble insertion active; 0: in_ready ignores hazards
//  CNT_W         16  width of the saturating bubble counter
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  in_valid      in   1      in_instr valid
//  in_ready      out  1      stage accepts in_instr this cycle
//  in_instr      in   32     instruction word
//  flush         in   1      kill held and incoming instruction
//  out_valid     out  1      control bundle valid
//  out_ready     in   1      execute accepts bundle
//  out_alu_src   out  2      00 rs2, 01 imm, 10 zero+imm (lui), 11 pc+imm (auipc)
//  out_alu_op    out  5      ctrl_pkg::alu_op_e
//  out_branch    out  1      conditional branch
//  out_jump      out  1      jal/jalr
//  out_mem_read  out  1      load
//  out_mem_write out  1      store
//  out_mem_to_reg out 1      writeback from memory
//  out_reg_write out  1      rd write enable (forced 0 when rd==x0)
//  out_funct3    out  3      branch condition / memory size
//  out_rd, out_rs1, out_rs2  out  5 each  register indices
//  out_illegal   out  1      illegal encoding; all side-effect strobes forced 0
//  bubble_cnt    out  CNT_W  number of bubbles inserted, saturating
// BEHAVIOUR
//  - Reset values: every out_* = 0, bubble_cnt = 0. in_ready is combinational; it is 1 after reset.
//  - Handshakes: a transfer occurs when valid & ready are both 1.
//    * out_valid, once 1, holds and the bundle stays stable until out_ready.
//    * in_ready = ~flush & ~hazard & (~out_valid | out_ready).
//  - Latency: one cycle from in transfer to out_valid.
//    * Full throughput when there is no hazard and out_ready is held high.
//  - alu_op encoding:
//    * 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu,
//      10 mul, 11 mulh, 12 mulhsu, 13 mulhu, 14 div, 15 divu, 16 rem, 17 remu, 18 copy_b.
//  - Decode:
//    * Load, store, jal, jalr: add.
//    * Branch: sub.
//    * lui: copy_b with alu_src 10. auipc: add with alu_src 11.
//    * I-type shifts require funct7 0000000, or 0100000 for srai.
//  - Illegal encodings:
//    * unknown opcode;
//    * unlisted {funct7,funct3} combinations;
//    * branch funct3 010/011;
//    * load funct3 011/110/111; store funct3 >= 011.
//    * An illegal instruction is still transferred with out_illegal=1.
//  - Hazard (ENABLE_HAZARD=1):
//    * Condition: out_valid & out_mem_read & out_rd!=0 & in_valid, and the incoming instruction reads out_rd as rs1 or rs2.
//    * Only instruction classes that actually use rs1/rs2 count as readers.
//    * While hazard is high, in_ready=0. When out_ready=1 the register loads a bubble (out_valid=0) and bubble_cnt increments.
//    * On the next cycle the hazard has cleared and the instruction is accepted, so exactly one bubble is inserted per load-use pair.
//  - Flush:
//    * out_valid=0 next cycle; in_ready=0 this cycle, so incoming data is dropped.
//    * Flush has priority over the hazard and over out_ready stalls. A flush does not increment bubble_cnt.
//  - bubble_cnt saturates at all-ones and does not wrap.
//  - rst asserted mid-operation clears state immediately; the in-flight instruction is lost.
// STRUCTURE
//  - Package ctrl_pkg:
//    * alu_op_e (5-bit enum);
//    * opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
//    * ctrl_t packed struct carrying every out_* field except valid;
//    * ALU_OP_W=5.
//  - Sub-module rv_decode_comb (purely combinational instr -> ctrl_t, plus rs1/rs2-used flags; takes parameter ENABLE_M).
//  - The top level holds the pipeline register, hazard logic, flush handling and counter.
// TESTING
//  1. add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu_op=0, alu_src=00, reg_write=1, rd=3.
//  2. lw x5,0(x1), then add x6,x5,x2 back-to-back -> one cycle with out_valid=0, bubble_cnt=1, then add issues; add x6,x7,x2 after the lw -> no bubble.
//  3. out_ready=0 for 3 cycles with sub held -> bundle is stable, in_ready=0; releasing out_ready gives one transfer and no duplicate.
//  4. flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, incoming instruction dropped, bubble_cnt unchanged.
//  5. mul x1,x2,x3 (0x023100B3): ENABLE_M=1 -> alu_op=10; ENABLE_M=0 -> out_illegal=1, reg_write=0; opcode 0x7F -> illegal.
//  6. Force bubble_cnt to its maximum (CNT_W=4: 15 hazards), then one more hazard -> bubble_cnt stays 15; rst mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the decode/control stage: ALU op codes, opcodes, control bundle.
package ctrl_pkg;

  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17,
    ALU_COPY_B = 5'd18
  } alu_op_e;

  // RV32I major opcodes
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU operand-B / operand-A selection
  localparam logic [1:0] SRC_RS2 = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_LUI = 2'b10;
  localparam logic [1:0] SRC_PC  = 2'b11;

  typedef struct packed {
    logic [1:0] alu_src;
    alu_op_e    alu_op;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I(+M) decoder: instruction word -> control bundle and
// register-read flags used by the load-use hazard check.
module rv_decode_comb
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        rs1_used,
  output logic        rs2_used
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       illegal;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // funct3 -> op shared by register and immediate ALU forms
  function automatic alu_op_e base_op(input logic [2:0] f);
    case (f)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  // Per-opcode decode; illegal encodings are scrubbed of all side effects at the end
  always_comb begin
    ctrl     = '0;
    illegal  = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    ctrl.funct3 = f3;
    ctrl.rd     = instr[11:7];
    ctrl.rs1    = instr[19:15];
    ctrl.rs2    = instr[24:20];
    case (opc)
      OP: begin
        ctrl.alu_src   = SRC_RS2;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        if (f7 == F7_BASE)                      ctrl.alu_op = base_op(f3);
        else if (f7 == F7_ALT && f3 == 3'b000)  ctrl.alu_op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)  ctrl.alu_op = ALU_SRA;
        else if (ENABLE_M && f7 == F7_MULDIV)   ctrl.alu_op = alu_op_e'(5'(ALU_MUL) + {2'b00, f3});
        else                                    illegal = 1'b1;
      end
      OP_IMM: begin
        ctrl.alu_src   = SRC_IMM;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
        if (f3 == 3'b001) begin
          if (f7 == F7_BASE) ctrl.alu_op = ALU_SLL;
          else               illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          if (f7 == F7_BASE)     ctrl.alu_op = ALU_SRL;
          else if (f7 == F7_ALT) ctrl.alu_op = ALU_SRA;
          else                   illegal = 1'b1;
        end else begin
          ctrl.alu_op = base_op(f3);
        end
      end
      LOAD: begin
        ctrl.alu_src    = SRC_IMM;
        ctrl.alu_op     = ALU_ADD;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        rs1_used        = 1'b1;
        illegal         = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      STORE: begin
        ctrl.alu_src   = SRC_IMM;
        ctrl.alu_op    = ALU_ADD;
        ctrl.mem_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        illegal        = (f3 >= 3'b011);
      end
      BRANCH: begin
        ctrl.alu_src = SRC_RS2;
        ctrl.alu_op  = ALU_SUB;
        ctrl.branch  = 1'b1;
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
        illegal      = (f3 == 3'b010) || (f3 == 3'b011);
      end
      JAL: begin
        // target = pc + imm
        ctrl.alu_src   = SRC_PC;
        ctrl.alu_op    = ALU_ADD;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      JALR: begin
        // target = rs1 + imm; only funct3 000 is defined
        ctrl.alu_src   = SRC_IMM;
        ctrl.alu_op    = ALU_ADD;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
        illegal        = (f3 != 3'b000);
      end
      LUI: begin
        ctrl.alu_src   = SRC_LUI;
        ctrl.alu_op    = ALU_COPY_B;
        ctrl.reg_write = 1'b1;
      end
      AUIPC: begin
        ctrl.alu_src   = SRC_PC;
        ctrl.alu_op    = ALU_ADD;
        ctrl.reg_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      ctrl.alu_src    = SRC_RS2;
      ctrl.alu_op     = ALU_ADD;
      ctrl.branch     = 1'b0;
      ctrl.jump       = 1'b0;
      ctrl.mem_read   = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.mem_to_reg = 1'b0;
      ctrl.reg_write  = 1'b0;
      rs1_used        = 1'b0;
      rs2_used        = 1'b0;
    end
    // x0 is hardwired; never request a write to it
    ctrl.reg_write = ctrl.reg_write & (ctrl.rd != 5'd0);
    ctrl.illegal   = illegal;
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode/control stage: one-entry pipeline register with
// valid/ready on both sides, load-use bubble insertion and flush.
module decode_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M      = 1'b0,
  parameter bit ENABLE_HAZARD = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_alu_src,
  output logic [4:0]       out_alu_op,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic             out_reg_write,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  ctrl_t dec;
  ctrl_t held;
  logic  rs1_used;
  logic  rs2_used;
  logic  hazard;
  logic  accept;
  logic  bubble;

  rv_decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (
    .instr    (in_instr),
    .ctrl     (dec),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  // Held load whose rd is read by the incoming instruction: stall it one cycle
  assign hazard = ENABLE_HAZARD && out_valid && held.mem_read && (held.rd != 5'd0) && in_valid &&
                  ((rs1_used && (dec.rs1 == held.rd)) || (rs2_used && (dec.rs2 == held.rd)));

  assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  // A bubble is only counted when the load actually leaves and nothing replaces it
  assign bubble   = hazard & out_ready & ~flush;

  // Pipeline register: flush kills, accept loads, consumption empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      held      <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign out_alu_src    = held.alu_src;
  assign out_alu_op     = held.alu_op;
  assign out_branch     = held.branch;
  assign out_jump       = held.jump;
  assign out_mem_read   = held.mem_read;
  assign out_mem_write  = held.mem_write;
  assign out_mem_to_reg = held.mem_to_reg;
  assign out_reg_write  = held.reg_write;
  assign out_funct3     = held.funct3;
  assign out_rd         = held.rd;
  assign out_rs1        = held.rs1;
  assign out_rs2        = held.rs2;
  assign out_illegal    = held.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage: directed scenarios plus random
// traffic against a behavioural decode/pipeline model.
module tb_decode_ctrl_stage;

  localparam logic [31:0] ADD_X3  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] LW_X5   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] ADD_DEP = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] ADD_IND = 32'h00238333; // add x6,x7,x2
  localparam logic [31:0] SUB_X4  = 32'h40208233; // sub x4,x1,x2
  localparam logic [31:0] ADDI_X7 = 32'h00508393; // addi x7,x1,5
  localparam logic [31:0] MUL_X1  = 32'h023100B3; // mul x1,x2,x3
  localparam logic [31:0] BAD_OPC = 32'h00000FFF; // opcode 0x7F, rd x31

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic        in_ready, out_valid;
  logic [1:0]  out_alu_src;
  logic [4:0]  out_alu_op, out_rd, out_rs1, out_rs2;
  logic        out_branch, out_jump, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write, out_illegal;
  logic [2:0]  out_funct3;
  logic [3:0]  bubble_cnt;

  // second instance without the M extension, sharing the inputs
  logic        n_in_ready, n_out_valid;
  logic [1:0]  n_alu_src;
  logic [4:0]  n_alu_op, n_rd, n_rs1, n_rs2;
  logic        n_branch, n_jump, n_mem_read, n_mem_write, n_mem_to_reg, n_reg_write, n_illegal;
  logic [2:0]  n_funct3;
  logic [15:0] n_bubble_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage #(.ENABLE_M(1'b1), .ENABLE_HAZARD(1'b1), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_src(out_alu_src), .out_alu_op(out_alu_op), .out_branch(out_branch), .out_jump(out_jump),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .out_reg_write(out_reg_write), .out_funct3(out_funct3), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_illegal(out_illegal), .bubble_cnt(bubble_cnt)
  );

  decode_ctrl_stage #(.ENABLE_M(1'b0), .ENABLE_HAZARD(1'b1), .CNT_W(16)) u_nom (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr),
    .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_alu_src(n_alu_src), .out_alu_op(n_alu_op), .out_branch(n_branch), .out_jump(n_jump),
    .out_mem_read(n_mem_read), .out_mem_write(n_mem_write), .out_mem_to_reg(n_mem_to_reg),
    .out_reg_write(n_reg_write), .out_funct3(n_funct3), .out_rd(n_rd), .out_rs1(n_rs1),
    .out_rs2(n_rs2), .out_illegal(n_illegal), .bubble_cnt(n_bubble_cnt)
  );

  typedef struct packed {
    logic [1:0] src;
    logic [4:0] op;
    logic       br, jmp, mr, mw, m2r, rw;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic       ill;
  } exp_t;

  // Reference decode straight from the ISA tables
  function automatic exp_t ref_decode(input logic [31:0] w, input bit em);
    exp_t       e;
    logic [4:0] base [8];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    bit         ill;
    base = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd4, 5'd6, 5'd3, 5'd2};
    e = '0;
    ill = 1'b0;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    e.f3 = f3; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    case (opc)
      7'h33: begin
        e.src = 2'd0; e.rw = 1'b1;
        if (f7 == 7'h00) e.op = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = 5'd7;
        else if (f7 == 7'h01 && em) e.op = 5'd10 + 5'(f3);
        else ill = 1'b1;
      end
      7'h13: begin
        e.src = 2'd1; e.rw = 1'b1;
        if (f3 == 3'd1) begin
          if (f7 == 7'h00) e.op = 5'd5; else ill = 1'b1;
        end else if (f3 == 3'd5) begin
          if (f7 == 7'h00) e.op = 5'd6; else if (f7 == 7'h20) e.op = 5'd7; else ill = 1'b1;
        end else e.op = base[f3];
      end
      7'h03: begin e.src = 2'd1; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1; ill = (f3 == 3'd3) || (f3 >= 3'd6); end
      7'h23: begin e.src = 2'd1; e.mw = 1'b1; ill = (f3 >= 3'd3); end
      7'h63: begin e.op = 5'd1; e.br = 1'b1; ill = (f3 == 3'd2) || (f3 == 3'd3); end
      7'h6F: begin e.src = 2'd3; e.jmp = 1'b1; e.rw = 1'b1; end
      7'h67: begin e.src = 2'd1; e.jmp = 1'b1; e.rw = 1'b1; ill = (f3 != 3'd0); end
      7'h37: begin e.src = 2'd2; e.op = 5'd18; e.rw = 1'b1; end
      7'h17: begin e.src = 2'd3; e.rw = 1'b1; end
      default: ill = 1'b1;
    endcase
    if (e.rd == 5'd0) e.rw = 1'b0;
    if (ill) begin
      e.src = 2'd0; e.op = 5'd0;
      e.br = 1'b0; e.jmp = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.m2r = 1'b0; e.rw = 1'b0;
    end
    e.ill = ill;
    return e;
  endfunction

  // Does legal instruction w read register r as a source operand?
  function automatic bit reads(input logic [31:0] w, input logic [4:0] r);
    exp_t e;
    bit   u1, u2;
    e = ref_decode(w, 1'b1);
    if (e.ill) return 1'b0;
    u1 = (w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67});
    u2 = (w[6:0] inside {7'h33, 7'h23, 7'h63});
    return (u1 && w[19:15] == r) || (u2 && w[24:20] == r);
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.src = out_alu_src; o.op = out_alu_op; o.br = out_branch; o.jmp = out_jump;
    o.mr = out_mem_read; o.mw = out_mem_write; o.m2r = out_mem_to_reg; o.rw = out_reg_write;
    o.f3 = out_funct3; o.rd = out_rd; o.rs1 = out_rs1; o.rs2 = out_rs2; o.ill = out_illegal;
    return o;
  endfunction

  // Model state: held bundle, its valid bit and the bubble count
  bit   m_valid;
  exp_t m_b;
  int   m_cnt;
  logic exp_rdy, obs_rdy;

  task automatic model_clear();
    m_valid = 1'b0; m_b = '0; m_cnt = 0;
  endtask

  // One clock: drive at edge+1, sample in_ready at negedge, advance model, settle to edge+1
  task automatic drive(input logic iv, input logic [31:0] w, input logic fl, input logic ordy);
    bit haz;
    in_valid = iv; in_instr = w; flush = fl; out_ready = ordy;
    @(negedge clk);
    obs_rdy = in_ready;
    haz = m_valid && m_b.mr && (m_b.rd != 5'd0) && iv && reads(w, m_b.rd);
    exp_rdy = !fl && !haz && (!m_valid || ordy);
    @(posedge clk);
    if (fl) m_valid = 1'b0;
    else if (iv && exp_rdy) begin m_valid = 1'b1; m_b = ref_decode(w, 1'b1); end
    else if (ordy) m_valid = 1'b0;
    if (haz && ordy && !fl && m_cnt < 15) m_cnt++;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, d;
    logic [6:0] f7;
    a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); d = 5'($urandom_range(0, 3));
    f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    case ($urandom_range(0, 9))
      0: return {12'd4, a, 3'd2, d, 7'h03};
      1: return {7'h00, b, a, 3'd0, d, 7'h33};
      2: return {7'h20, b, a, 3'd0, d, 7'h33};
      3: return {12'd9, a, 3'd0, d, 7'h13};
      4: return {7'h00, b, a, 3'($urandom_range(0, 4)), 5'd0, 7'h23};
      5: return {7'h00, b, a, 3'($urandom_range(0, 7)), 5'd8, 7'h63};
      6: return {20'h00010, d, 7'h6F};
      7: return {f7, b, a, 3'd5, d, 7'h13};
      8: return {7'h01, b, a, 3'($urandom_range(0, 7)), d, 7'h33};
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    apply_reset();
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_assert++; if (obs() !== exp_t'(0)) begin n_fail++; $display("FAIL reset_bundle: got %h want 0", obs()); end
    n_assert++; if (bubble_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    drive(1'b1, ADD_X3, 1'b0, 1'b1);
    n_assert++; if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL add_in_ready: got %b want 1", obs_rdy); end
    n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_assert++; if (out_alu_op !== 5'd0 || out_alu_src !== 2'b00) begin n_fail++; $display("FAIL add_op: got op %0d src %b want 0/00", out_alu_op, out_alu_src); end
    n_assert++; if (out_reg_write !== 1'b1 || out_rd !== 5'd3) begin n_fail++; $display("FAIL add_rd: got rw %b rd %0d want 1/3", out_reg_write, out_rd); end
    n_assert++; if (obs() !== m_b) begin n_fail++; $display("FAIL add_bundle: got %h want %h", obs(), m_b); end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_load_use();
    drive(1'b1, LW_X5, 1'b0, 1'b1);
    n_assert++; if (out_valid !== 1'b1 || out_mem_read !== 1'b1) begin n_fail++; $display("FAIL lu_load: got v %b mr %b want 1/1", out_valid, out_mem_read); end
    drive(1'b1, ADD_DEP, 1'b0, 1'b1);
    n_assert++; if (obs_rdy !== 1'b0) begin n_fail++; $display("FAIL lu_stall_ready: got %b want 0", obs_rdy); end
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %b want 0", out_valid); end
    n_assert++; if (bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", bubble_cnt); end
    drive(1'b1, ADD_DEP, 1'b0, 1'b1);
    n_assert++; if (obs_rdy !== 1'b1 || out_valid !== 1'b1 || out_rd !== 5'd6) begin n_fail++; $display("FAIL lu_issue: got rdy %b v %b rd %0d want 1/1/6", obs_rdy, out_valid, out_rd); end
    drive(1'b1, LW_X5, 1'b0, 1'b1);
    drive(1'b1, ADD_IND, 1'b0, 1'b1);
    n_assert++; if (obs_rdy !== 1'b1 || out_valid !== 1'b1 || bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_nodep: got rdy %b v %b cnt %0d want 1/1/1", obs_rdy, out_valid, bubble_cnt); end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    exp_t snap;
    drive(1'b1, SUB_X4, 1'b0, 1'b0);
    snap = ref_decode(SUB_X4, 1'b1);
    n_assert++; if (out_valid !== 1'b1 || out_alu_op !== 5'd1) begin n_fail++; $display("FAIL stall_load: got v %b op %0d want 1/1", out_valid, out_alu_op); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDI_X7, 1'b0, 1'b0);
      n_assert++; if (obs_rdy !== 1'b0 || out_valid !== 1'b1 || obs() !== snap) begin n_fail++; $display("FAIL stall_hold: got rdy %b v %b %h want 0/1 %h", obs_rdy, out_valid, obs(), snap); end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, ADD_X3, 1'b0, 1'b1);
    drive(1'b1, ADDI_X7, 1'b1, 1'b0);
    n_assert++; if (obs_rdy !== 1'b0 || out_valid !== 1'b0 || bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL flush_kill: got rdy %b v %b cnt %0d want 0/0/1", obs_rdy, out_valid, bubble_cnt); end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b want 0", out_valid); end
    drive(1'b1, LW_X5, 1'b0, 1'b1);
    drive(1'b1, ADD_DEP, 1'b1, 1'b1);
    n_assert++; if (out_valid !== 1'b0 || bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL flush_hazard: got v %b cnt %0d want 0/1", out_valid, bubble_cnt); end
  endtask

  task automatic test_mext();
    drive(1'b1, MUL_X1, 1'b0, 1'b1);
    n_assert++; if (out_alu_op !== 5'd10 || out_illegal !== 1'b0 || out_reg_write !== 1'b1) begin n_fail++; $display("FAIL mul_m: got op %0d ill %b rw %b want 10/0/1", out_alu_op, out_illegal, out_reg_write); end
    n_assert++; if (n_illegal !== 1'b1 || n_reg_write !== 1'b0) begin n_fail++; $display("FAIL mul_nom: got ill %b rw %b want 1/0", n_illegal, n_reg_write); end
    drive(1'b1, BAD_OPC, 1'b0, 1'b1);
    n_assert++; if (out_illegal !== 1'b1 || n_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bad_opc: got ill %b/%b rw %b v %b want 1/1/0/1", out_illegal, n_illegal, out_reg_write, out_valid); end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, LW_X5, 1'b0, 1'b1);
      drive(1'b1, ADD_DEP, 1'b0, 1'b1);
      drive(1'b1, ADD_DEP, 1'b0, 1'b1);
    end
    n_assert++; if (bubble_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d want 15", bubble_cnt); end
    drive(1'b1, LW_X5, 1'b0, 1'b1);
    drive(1'b1, ADD_DEP, 1'b0, 1'b1);
    n_assert++; if (bubble_cnt !== 4'd15 || out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_hold: got cnt %0d v %b want 15/0", bubble_cnt, out_valid); end
    drive(1'b1, LW_X5, 1'b0, 1'b1);
    in_valid = 1'b1; in_instr = ADD_IND; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_assert++; if (out_valid !== 1'b0 || obs() !== exp_t'(0) || bubble_cnt !== 4'd0) begin n_fail++; $display("FAIL async_rst: got v %b %h cnt %0d want 0/0/0", out_valid, obs(), bubble_cnt); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic iv, fl, ordy;
    logic [31:0] w;
    for (int i = 0; i < 400; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      w    = rand_instr();
      drive(iv, w, fl, ordy);
      n_assert++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, obs_rdy, exp_rdy); end
      n_assert++; if (out_valid !== m_valid || bubble_cnt !== 4'(m_cnt)) begin n_fail++; $display("FAIL rnd_state[%0d]: got v %b cnt %0d want %b/%0d", i, out_valid, bubble_cnt, m_valid, m_cnt); end
      if (m_valid) begin
        n_assert++; if (obs() !== m_b) begin n_fail++; $display("FAIL rnd_bundle[%0d]: got %h want %h", i, obs(), m_b); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_stall();
    test_flush();
    test_mext();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
